// File: rtl/uart_transmitter_pkg.sv
// Shared UART definitions: state encodings, frame constants and default line timing,
// so the transmit and receive sides agree on the same values.
package uart_transmitter_pkg;

   localparam int   DEFAULT_CLOCK_FREQ = 50_000_000;
   localparam int   DEFAULT_BAUD_RATE  = 115_200;
   localparam int   DATA_BITS          = 8;
   localparam logic IDLE_LEVEL         = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;

   // Clock cycles per bit, truncated.
   function automatic int baud_divisor(input int clock_freq, input int baud_rate);
      return clock_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..N-1 and flags the last cycle of every bit.
module uart_baud_counter #(
   parameter int N = 434
) (
   input  logic Clock,
   input  logic Reset,
   input  logic Clear,
   output logic BitDone
);

   localparam int            CW   = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   logic [CW-1:0] r_count;

   // NOTE: sequential state is always updated with <= so every flop samples pre-edge values.
   always_ff @(posedge Clock) begin
      if (Reset || Clear || (r_count == LAST)) r_count <= '0;
      else                                     r_count <= r_count + CW'(1);
   end

   assign BitDone = (r_count == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with valid/ready byte input and a registered TX pin.
// Optional even parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_transmitter
   import uart_transmitter_pkg::*;
#(
   parameter int ClockFreq = DEFAULT_CLOCK_FREQ,
   parameter int BaudRate  = DEFAULT_BAUD_RATE
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [7:0] DataIn,
   input  logic       DataInValid,
   output logic       DataInReady,
   output logic       SOut
);

   localparam int         N          = baud_divisor(ClockFreq, BaudRate);
   localparam logic [2:0] LAST_INDEX = 3'(DATA_BITS - 1);

   tx_state_t  r_state, w_next_state;
   logic [7:0] r_shift, w_shift_next;
   logic [2:0] r_index, w_index_next;
   logic       r_sout,  w_sout_next;
   logic       w_bit_done;
   logic       w_clear;

   // Timer is held cleared while idle so every frame starts from a full bit period.
   assign w_clear = (r_state == ST_IDLE);

   uart_baud_counter #(.N(N)) u_baud (
      .Clock   (Clock),
      .Reset   (Reset),
      .Clear   (w_clear),
      .BitDone (w_bit_done)
   );

`ifdef UART_TX_PARITY_EN
   logic r_parity;

   always_ff @(posedge Clock) begin
      if (Reset)                                      r_parity <= 1'b0;
      else if (r_state == ST_IDLE && DataInValid)     r_parity <= ^DataIn;
   end
`endif

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_shift_next = r_shift;
      w_index_next = r_index;
      w_sout_next  = r_sout;
      case (r_state)
         ST_IDLE: begin
            w_sout_next = IDLE_LEVEL;
            if (DataInValid) begin
               w_next_state = ST_START;
               w_shift_next = DataIn;
               w_index_next = '0;
               w_sout_next  = 1'b0;
            end
         end
         ST_START: if (w_bit_done) begin
            w_next_state = ST_DATA;
            w_sout_next  = r_shift[0];
         end
         ST_DATA: if (w_bit_done) begin
            if (r_index == LAST_INDEX) begin
`ifdef UART_TX_PARITY_EN
               w_next_state = ST_PARITY;
               w_sout_next  = r_parity;
`else
               w_next_state = ST_STOP;
               w_sout_next  = IDLE_LEVEL;
`endif
            end else begin
               w_index_next = r_index + 3'd1;
               w_shift_next = r_shift >> 1;
               w_sout_next  = r_shift[1];
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: if (w_bit_done) begin
            w_next_state = ST_STOP;
            w_sout_next  = IDLE_LEVEL;
         end
`endif
         ST_STOP: if (w_bit_done) begin
            w_next_state = ST_IDLE;
            w_sout_next  = IDLE_LEVEL;
         end
         default: begin
            w_next_state = ST_IDLE;
            w_sout_next  = IDLE_LEVEL;
         end
      endcase
   end

   // NOTE: the shift register is reset too, so a frame aborted by reset leaves no stale byte.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state <= ST_IDLE;
         r_shift <= '0;
         r_index <= '0;
         r_sout  <= IDLE_LEVEL;
      end else begin
         r_state <= w_next_state;
         r_shift <= w_shift_next;
         r_index <= w_index_next;
         r_sout  <= w_sout_next;
      end
   end

   assign DataInReady = (r_state == ST_IDLE);
   assign SOut        = r_sout;

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter at N=10: stimulus queues expected bytes,
// a line monitor decodes SOut frames and compares them. Honors UART_TX_PARITY_EN.
module tb_uart_transmitter;

   localparam int N = 10;
`ifdef UART_TX_PARITY_EN
   localparam int NPH = 11;
`else
   localparam int NPH = 10;
`endif
   localparam int FRAME = NPH * N;

   typedef struct {
      logic [7:0] data;
      logic       par;
   } exp_t;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic [7:0] DataIn = 8'h00;
   logic       DataInValid = 1'b0;
   logic       DataInReady;
   logic       SOut;

   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   rst_edges = 0;
   int   frames_done = 0;
   int   aborts = 0;
   int   mon_start_cyc = -1;
   exp_t exp_q[$];

   uart_transmitter #(.ClockFreq(100), .BaudRate(10)) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .DataIn      (DataIn),
      .DataInValid (DataInValid),
      .DataInReady (DataInReady),
      .SOut        (SOut)
   );

   always #5 Clock = ~Clock;

   always @(posedge Clock) begin
      cyc <= cyc + 1;
      if (Reset) rst_edges <= rst_edges + 1;
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Offers a byte from a negedge; returns the cycle index of the first start-bit period.
   task automatic send(input logic [7:0] b, input logic par, input bit hold, output int t_acc);
      bit   done;
      exp_t e;
      done  = 0;
      t_acc = -1;
      DataIn = b;
      DataInValid = 1'b1;
      for (int i = 0; i < 500 && !done; i++) begin
         if (DataInReady === 1'b1 && !Reset) begin
            @(posedge Clock);
            e.data = b;
            e.par  = par;
            exp_q.push_back(e);
            done = 1;
            @(negedge Clock);
            t_acc = cyc;
            if (!hold) DataInValid = 1'b0;
         end else begin
            @(negedge Clock);
         end
      end
      if (!done) check("accept_timeout", 0, 1);
   endtask

   task automatic wait_frames(input int target);
      for (int i = 0; i < 3000 && frames_done < target; i++) @(negedge Clock);
      check("frame_count", frames_done, target);
   endtask

   task automatic wait_until_cyc(input int c);
      for (int i = 0; i < 3000 && cyc < c; i++) @(negedge Clock);
   endtask

   // Monitor: decodes frames on SOut, checks hold times and pops the scoreboard.
   initial begin
      logic [10:0] lvl;
      bit          hold_ok;
      bit          aborted;
      int          base;
      int          start;
      exp_t        e;
      forever begin
         @(negedge Clock);
         if (SOut === 1'b0) begin
            start   = cyc;
            base    = rst_edges;
            lvl     = '0;
            hold_ok = 1;
            aborted = 0;
            for (int p = 0; p < NPH && !aborted; p++) begin
               for (int j = 0; j < N && !aborted; j++) begin
                  if (!(p == 0 && j == 0)) @(negedge Clock);
                  if (rst_edges != base)  aborted = 1;
                  else if (j == 0)        lvl[p] = SOut;
                  else if (SOut !== lvl[p]) hold_ok = 0;
               end
            end
            if (aborted) begin
               aborts++;
               if (exp_q.size() > 0) void'(exp_q.pop_front());
            end else begin
               mon_start_cyc = start;
               check("bit_hold", int'(hold_ok), 1);
               check("stop_bit", int'(lvl[NPH-1]), 1);
               if (exp_q.size() == 0) begin
                  check("unexpected_frame", int'(lvl[8:1]), -1);
               end else begin
                  e = exp_q.pop_front();
                  check("frame_data", int'(lvl[8:1]), int'(e.data));
`ifdef UART_TX_PARITY_EN
                  check("parity_bit", int'(lvl[9]), int'(e.par));
`endif
               end
               frames_done++;
            end
         end
      end
   end

   initial begin
      int t1, t2, bad;

      // Reset held 3 cycles, then idle behaviour.
      repeat (3) @(posedge Clock);
      @(negedge Clock);
      Reset = 1'b0;
      @(negedge Clock);
      check("reset_sout", int'(SOut), 1);
      check("reset_ready", int'(DataInReady), 1);
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         if (SOut !== 1'b1 || DataInReady !== 1'b1) bad++;
         @(negedge Clock);
      end
      check("idle_stable", bad, 0);
      check("idle_no_frame", frames_done, 0);

      // Single byte 0x55: start alignment and ready window.
      send(8'h55, 1'b0, 0, t1);
      bad = 0;
      for (int i = 0; i < FRAME; i++) begin
         if (DataInReady !== 1'b0) bad++;
         if (i < FRAME - 1) @(negedge Clock);
      end
      check("busy_ready_low", bad, 0);
      @(negedge Clock);
      check("ready_return_cyc", cyc - t1, FRAME);
      check("ready_return", int'(DataInReady), 1);
      wait_frames(1);
      check("start_align", mon_start_cyc, t1);

      // Back-to-back with valid held high: one idle cycle between frames.
      send(8'hA5, 1'b0, 1, t1);
      send(8'h3C, 1'b0, 1, t2);
      DataInValid = 1'b0;
      check("b2b_period", t2 - t1, FRAME + 1);
      wait_frames(3);
      check("b2b_start_align", mon_start_cyc, t2);

      // Data stability: new byte offered mid-frame waits for ready.
      send(8'hF0, 1'b0, 0, t1);
      wait_until_cyc(t1 + 30);
      DataIn = 8'h0F;
      DataInValid = 1'b1;
      bad = 0;
      while (cyc < t1 + FRAME) begin
         if (DataInReady !== 1'b0) bad++;
         @(negedge Clock);
      end
      check("stable_busy", bad, 0);
      send(8'h0F, 1'b0, 0, t2);
      check("stable_second_accept", t2 - t1, FRAME + 1);
      wait_frames(5);

      // Reset during bit 3 of 0x00, then a clean 0x81.
      send(8'h00, 1'b0, 0, t1);
      wait_until_cyc(t1 + 4 * N + 4);
      Reset = 1'b1;
      @(negedge Clock);
      check("midreset_sout", int'(SOut), 1);
      check("midreset_ready", int'(DataInReady), 1);
      Reset = 1'b0;
      @(negedge Clock);
      check("midreset_abort", aborts, 1);
      send(8'h81, 1'b0, 0, t1);
      wait_frames(6);
      check("post_reset_align", mon_start_cyc, t1);

`ifdef UART_TX_PARITY_EN
      send(8'h07, 1'b1, 0, t1);
      wait_until_cyc(t1 + 110);
      check("parity_ready_cyc", int'(DataInReady), 1);
      wait_frames(7);
      send(8'h03, 1'b0, 0, t1);
      wait_frames(8);
`endif

      check("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
